thor2022_rc_issue_pipe: RTL and testbench
=========================================

Name: thor2022_rc_issue_pipe

Overview:
- Multi-lane successor to the single-instruction target-register (Rc) decoder.
- Takes a group of LANES predecoded target selectors per cycle and translates each to a physical register number, applying stack-pointer banking and link-register aliasing.
- Blocks issue on write-after-write hazards against a pending-write scoreboard, and presents groups to register-read through a 2-entry valid/ready buffer.
- Sits between instruction decode and register-read/issue.

Parameters:
- LANES, 2: instructions per group.
- PREGS, 64: physical register count; PW = $clog2(PREGS).
- SP_AREG, 31: architectural SP number subject to banking.
- SP_BASE, 44: physical SP for bank 1; bank n maps to SP_BASE+n-1, n=1..SP_BANKS.
- SP_BANKS, 4: number of alternate SP banks.
- LK_BASE, 41: link aliases. Field 29 maps to LK_BASE; field 30 maps to LK_BASE+1.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-low.
- flush_i, in, 1: discard buffered groups.
- spsel_we_i, in, 1: write SP bank select.
- spsel_i, in, 3: new bank select (0 = no banking).
- in_valid_i, in, 1: input group valid.
- in_ready_o, out, 1: group accepted when in_valid_i & in_ready_o.
- in_cls_i, in, LANES*3: per-lane selector class (package enum rc_cls_t).
- in_fld_i, in, LANES*6: per-lane raw field.
- out_valid_o, out, 1: output group valid.
- out_ready_i, in, 1: consumer ready.
- out_rc_o, out, LANES*PW: physical target register per lane.
- out_wr_o, out, LANES: lane writes out_rc_o.
- wb_v_i, in, 1: write-back retire valid.
- wb_reg_i, in, PW: retired register; clears its busy bit.
- busy_o, out, PREGS: scoreboard bits.

Behaviour:
- Class translation, per lane, combinational:
  - RC_R3: fld, bankable, wr=1.
  - RC_ST: {0,fld[4:0]}, bankable, wr=0 (store source).
  - RC_JXX: 29 maps to LK_BASE, 30 maps to LK_BASE+1, else {0,fld[4:0]}; not bankable; wr=1.
  - RC_SPF: SP_AREG, not bankable, wr=1.
  - RC_RTS: fld[1:0]==0 gives 0, else 40+fld[1:0]; wr=1.
  - RC_NONE: 0, wr=0.
- Banking: a bankable result equal to SP_AREG with spsel register n in 1..SP_BANKS becomes SP_BASE+n-1. Any other spsel value leaves it unchanged.
- wr forced 0 when the translated register is 0.
- Intra-group duplicates: if lanes i<j have equal translated registers with both wr=1, lane i's wr is cleared. The younger lane wins.
- Hazard: a group stalls if any lane with wr=1 targets a register that is busy, or that is a wr=1 target in either buffer entry.
- in_ready_o = buffer not full & no hazard & !flush_i.
- Latency: an accepted group appears on out_* the next cycle. The buffer is a 2-entry FIFO, so back-to-back groups sustain 1 per cycle with out_ready_i high.
- Busy bits:
  - Set for wr=1 lanes when a group leaves the buffer (out_valid_o & out_ready_i).
  - Cleared by wb_v_i & wb_reg_i!=0.
  - Same-cycle set and clear of one register: set wins. wb to register 0 is ignored.
- spsel register: written on spsel_we_i and applied to groups accepted from the following cycle. Buffered groups keep their translation.
- flush_i:
  - Empties the buffer in that cycle and blocks acceptance.
  - Busy bits are unchanged; flushed groups never set busy.
  - A handshake coinciding with flush still sets busy for the departing group.
- Full buffer with out_ready_i low: holds contents, in_ready_o = 0, outputs stable.
- Reset:
  - Buffer empty, out_valid_o = 0, out_rc_o = 0, out_wr_o = 0.
  - busy_o = 0, spsel = 0.
  - in_ready_o = 1 after deassert.

Optional Feature:
- THOR_RC_STALLCNT_EN. When defined:
  - Adds output stall_cnt_o [31:0], counting cycles with in_valid_i & !in_ready_o & !flush_i.
  - Saturates at 0xFFFFFFFF; reset to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Thor2022_pkg holds:
  - rc_cls_t enum (RC_NONE, RC_R3, RC_ST, RC_JXX, RC_SPF, RC_RTS).
  - Constants SP_AREG_DEF, SP_BASE_DEF, LK_BASE_DEF.
  - Buffer entry struct (rc, wr per lane).
- Sub-module thor2022_rc_xlate: a combinational single-lane translate, instantiated LANES times.

Test Plan:
1. spsel=2, lane0 RC_R3 fld 31, lane1 RC_JXX fld 29 -> next cycle out_rc = {45, 41}, out_wr = 2'b11, busy[45] and busy[41] set on handshake.
2. Lane0 RC_R3 fld 5 issued and handshaken; next group writes 5 -> in_ready_o = 0 until wb_v_i with reg 5. The group is accepted the same cycle the busy bit clears, and out_valid_o rises the cycle after.
3. Lane0 and lane1 both RC_R3 fld 7 -> out_wr = 2'b10 (lane1 only); busy[7] set once.
4. out_ready_i held 0 for 4 cycles with continuous distinct-target input -> 2 groups buffered, in_ready_o = 0 from the third cycle, outputs stable.
5. flush_i with 2 buffered groups -> out_valid_o = 0 next cycle, busy_o unchanged. Asserting rst_i low mid-stream clears busy_o immediately (async).
6. wb_v_i reg 9 coinciding with a handshake setting reg 9 -> busy[9] = 1. With THOR_RC_STALLCNT_EN, scenario 2 counts exactly the stalled cycles.

Source files
------------

// File: rtl/thor2022_rc_issue_pipe_pkg.sv
// Shared types and defaults for the multi-lane Rc target translate / issue pipe.
package thor2022_rc_issue_pipe_pkg;

  localparam int unsigned LANES_DEF    = 2;
  localparam int unsigned PREGS_DEF    = 64;
  localparam int unsigned PW           = $clog2(PREGS_DEF);
  localparam int unsigned SP_AREG_DEF  = 31;
  localparam int unsigned SP_BASE_DEF  = 44;
  localparam int unsigned SP_BANKS_DEF = 4;
  localparam int unsigned LK_BASE_DEF  = 41;

  typedef enum logic [2:0] {
    RC_NONE = 3'd0,
    RC_R3   = 3'd1,
    RC_ST   = 3'd2,
    RC_JXX  = 3'd3,
    RC_SPF  = 3'd4,
    RC_RTS  = 3'd5
  } rc_cls_t;

  // One buffered group: physical target and write flag per lane.
  typedef struct packed {
    logic [LANES_DEF-1:0][PW-1:0] rc;
    logic [LANES_DEF-1:0]         wr;
  } rc_entry_t;

endpackage

// File: rtl/thor2022_rc_xlate.sv
// Single-lane combinational translate of a predecoded Rc selector to a physical
// register, with SP banking and link-register aliasing.
module thor2022_rc_xlate
  import thor2022_rc_issue_pipe_pkg::*;
#(
  parameter int unsigned SP_AREG  = SP_AREG_DEF,
  parameter int unsigned SP_BASE  = SP_BASE_DEF,
  parameter int unsigned SP_BANKS = SP_BANKS_DEF,
  parameter int unsigned LK_BASE  = LK_BASE_DEF
) (
  input  rc_cls_t       cls,
  input  logic [5:0]    fld,
  input  logic [2:0]    spsel,
  output logic [PW-1:0] rc_c,
  output logic          wr_c
);

  logic [PW-1:0] raw;
  logic          bankable;

  always_comb begin
    raw      = '0;
    bankable = 1'b0;
    wr_c     = 1'b0;
    case (cls)
      RC_R3: begin
        raw      = PW'(fld);
        bankable = 1'b1;
        wr_c     = 1'b1;
      end
      RC_ST: begin
        raw      = PW'(fld[4:0]);
        bankable = 1'b1;
      end
      RC_JXX: begin
        if (fld == 6'd29)      raw = PW'(LK_BASE);
        else if (fld == 6'd30) raw = PW'(LK_BASE + 1);
        else                   raw = PW'(fld[4:0]);
        wr_c = 1'b1;
      end
      RC_SPF: begin
        raw  = PW'(SP_AREG);
        wr_c = 1'b1;
      end
      RC_RTS: begin
        raw  = (fld[1:0] == 2'd0) ? '0 : PW'(40 + 32'(fld[1:0]));
        wr_c = 1'b1;
      end
      default: ;
    endcase
    rc_c = raw;
    if (bankable && raw == PW'(SP_AREG) && 32'(spsel) >= 1 && 32'(spsel) <= SP_BANKS)
      rc_c = PW'(SP_BASE + 32'(spsel) - 1);
    // Register 0 is the zero register: never a real write.
    if (rc_c == '0) wr_c = 1'b0;
  end

endmodule

// File: rtl/thor2022_rc_issue_pipe.sv
// Multi-lane Rc issue pipe: translate, WAW hazard check against a busy scoreboard,
// 2-entry output FIFO. Optional THOR_RC_STALLCNT_EN adds a saturating stall counter.
module thor2022_rc_issue_pipe
  import thor2022_rc_issue_pipe_pkg::*;
#(
  parameter int unsigned SP_AREG  = SP_AREG_DEF,
  parameter int unsigned SP_BASE  = SP_BASE_DEF,
  parameter int unsigned SP_BANKS = SP_BANKS_DEF,
  parameter int unsigned LK_BASE  = LK_BASE_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        spsel_we_i,
  input  logic [2:0]                  spsel_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES_DEF*3-1:0]      in_cls_i,
  input  logic [LANES_DEF*6-1:0]      in_fld_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANES_DEF*PW-1:0]     out_rc_o,
  output logic [LANES_DEF-1:0]        out_wr_o,
  input  logic                        wb_v_i,
  input  logic [PW-1:0]               wb_reg_i,
  output logic [PREGS_DEF-1:0]        busy_o
`ifdef THOR_RC_STALLCNT_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned LANES = LANES_DEF;
  localparam int unsigned PREGS = PREGS_DEF;

  logic [2:0]            spsel_q;
  rc_entry_t [1:0]       ent_q, ent_n;
  logic [1:0]            cnt_q, cnt_n;
  logic [PREGS-1:0]      busy_q, busy_n, wb_clr;
  logic [PW-1:0]         x_rc [LANES];
  logic                  x_wr [LANES];
  rc_entry_t             grp;
  logic                  hazard, push, pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    thor2022_rc_xlate #(
      .SP_AREG (SP_AREG),
      .SP_BASE (SP_BASE),
      .SP_BANKS(SP_BANKS),
      .LK_BASE (LK_BASE)
    ) u_xlate (
      .cls  (rc_cls_t'(in_cls_i[g*3 +: 3])),
      .fld  (in_fld_i[g*6 +: 6]),
      .spsel(spsel_q),
      .rc_c (x_rc[g]),
      .wr_c (x_wr[g])
    );
  end

  // Younger lane wins an intra-group duplicate write.
  always_comb begin
    grp = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      grp.rc[i] = x_rc[i];
      grp.wr[i] = x_wr[i];
    end
    for (int unsigned i = 0; i < LANES; i++)
      for (int unsigned j = i + 1; j < LANES; j++)
        if (x_wr[i] && x_wr[j] && x_rc[i] == x_rc[j]) grp.wr[i] = 1'b0;
  end

  // WAW hazard; a write-back retiring this cycle already unblocks its register.
  // Invalid FIFO entries are held at zero, so no valid qualification is needed.
  always_comb begin
    wb_clr = '0;
    if (wb_v_i && wb_reg_i != '0) wb_clr[wb_reg_i] = 1'b1;
    hazard = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (grp.wr[i]) begin
        if (busy_q[grp.rc[i]] && !wb_clr[grp.rc[i]]) hazard = 1'b1;
        for (int unsigned e = 0; e < 2; e++)
          for (int unsigned k = 0; k < LANES; k++)
            if (ent_q[e].wr[k] && ent_q[e].rc[k] == grp.rc[i]) hazard = 1'b1;
      end
    end
  end

  assign in_ready_o  = (cnt_q != 2'd2) && !hazard && !flush_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = (cnt_q != 2'd0) && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_rc_o    = ent_q[0].rc;
  assign out_wr_o    = ent_q[0].wr;
  assign busy_o      = busy_q;

  // FIFO next state: shift on pop, append at the first free slot.
  always_comb begin
    ent_n = ent_q;
    cnt_n = cnt_q;
    if (flush_i) begin
      ent_n = '0;
      cnt_n = 2'd0;
    end else begin
      if (pop) begin
        ent_n[0] = ent_q[1];
        ent_n[1] = '0;
        cnt_n    = cnt_q - 2'd1;
      end
      if (push) begin
        ent_n[cnt_n[0]] = grp;
        cnt_n           = cnt_n + 2'd1;
      end
    end
  end

  // Scoreboard: set from the departing group overrides a same-cycle clear.
  always_comb begin
    busy_n = busy_q & ~wb_clr;
    if (pop)
      for (int unsigned k = 0; k < LANES; k++)
        if (ent_q[0].wr[k]) busy_n[ent_q[0].rc[k]] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      spsel_q <= '0;
      ent_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      if (spsel_we_i) spsel_q <= spsel_i;
      ent_q  <= ent_n;
      cnt_q  <= cnt_n;
      busy_q <= busy_n;
    end
  end

`ifdef THOR_RC_STALLCNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_q <= '0;
    else if (in_valid_i && !in_ready_o && !flush_i && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_thor2022_rc_issue_pipe.sv
// Self-checking bench for thor2022_rc_issue_pipe: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_thor2022_rc_issue_pipe;
  import thor2022_rc_issue_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, spsel_we, in_valid, in_ready, out_valid, out_ready, wb_v;
  logic [2:0]  spsel;
  logic [5:0]  in_cls;
  logic [11:0] in_fld;
  logic [11:0] out_rc;
  logic [1:0]  out_wr;
  logic [5:0]  wb_reg;
  logic [63:0] busy;
`ifdef THOR_RC_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  thor2022_rc_issue_pipe dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .flush_i    (flush),
    .spsel_we_i (spsel_we),
    .spsel_i    (spsel),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_cls_i   (in_cls),
    .in_fld_i   (in_fld),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_rc_o   (out_rc),
    .out_wr_o   (out_wr),
    .wb_v_i     (wb_v),
    .wb_reg_i   (wb_reg),
    .busy_o     (busy)
`ifdef THOR_RC_STALLCNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] rc1;
    logic [7:0] rc0;
    logic       wr1;
    logic       wr0;
  } mgrp_t;

  int          checks = 0;
  int          errors = 0;
  mgrp_t       m_q[$];
  logic [63:0] m_busy;
  int          m_sp;
  logic [31:0] m_stall;
  mgrp_t       cur;
  bit          exp_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference translation straight from the selector-class rules.
  function automatic void m_xl(input int cls, input int fld, input int sp,
                               output int rc, output bit wr);
    bit bk = 0;
    rc = 0;
    wr = 0;
    if (cls == int'(RC_R3)) begin rc = fld; bk = 1; wr = 1; end
    else if (cls == int'(RC_ST)) begin rc = fld % 32; bk = 1; end
    else if (cls == int'(RC_JXX)) begin
      rc = (fld == 29) ? 41 : (fld == 30) ? 42 : fld % 32;
      wr = 1;
    end
    else if (cls == int'(RC_SPF)) begin rc = 31; wr = 1; end
    else if (cls == int'(RC_RTS)) begin rc = (fld % 4 == 0) ? 0 : 40 + fld % 4; wr = 1; end
    if (bk && rc == 31 && sp >= 1 && sp <= 4) rc = 44 + sp - 1;
    if (rc == 0) wr = 0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy  = '0;
    m_sp    = 0;
    m_stall = '0;
  endtask

  // Settle after the input change and compare every output with the model.
  task automatic settle();
    int    rc [2];
    bit    wr [2];
    bit    haz;
    mgrp_t h;
    #1;
    for (int l = 0; l < 2; l++)
      m_xl(int'(in_cls[l*3 +: 3]), int'(in_fld[l*6 +: 6]), m_sp, rc[l], wr[l]);
    if (wr[0] && wr[1] && rc[0] == rc[1]) wr[0] = 0;
    haz = 0;
    for (int l = 0; l < 2; l++) begin
      if (wr[l]) begin
        if (m_busy[rc[l]] && !(wb_v && int'(wb_reg) == rc[l])) haz = 1;
        foreach (m_q[e])
          if ((m_q[e].wr0 && int'(m_q[e].rc0) == rc[l]) ||
              (m_q[e].wr1 && int'(m_q[e].rc1) == rc[l])) haz = 1;
      end
    end
    exp_rdy = (m_q.size() < 2) && !haz && !flush;
    cur.rc0 = 8'(rc[0]);
    cur.rc1 = 8'(rc[1]);
    cur.wr0 = wr[0];
    cur.wr1 = wr[1];
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("out_rc", 64'(out_rc), 64'({h.rc1[5:0], h.rc0[5:0]}));
    chk("out_wr", 64'(out_wr), 64'({h.wr1, h.wr0}));
    chk("busy", busy, m_busy);
`ifdef THOR_RC_STALLCNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // Advance the model across one active edge using the inputs the DUT sampled.
  task automatic tick();
    mgrp_t g;
    @(posedge clk);
    if (in_valid && !exp_rdy && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (wb_v && wb_reg != 6'd0) m_busy[wb_reg] = 1'b0;
    if (m_q.size() > 0 && out_ready) begin
      g = m_q.pop_front();
      if (g.wr0) m_busy[g.rc0[5:0]] = 1'b1;
      if (g.wr1) m_busy[g.rc1[5:0]] = 1'b1;
    end
    if (flush) m_q.delete();
    else if (in_valid && exp_rdy) m_q.push_back(cur);
    if (spsel_we) m_sp = int'(spsel);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; spsel_we = 0; wb_v = 0;
    in_cls = '0; in_fld = '0; wb_reg = '0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rc", 64'(out_rc), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    out_ready = 1'b1;
    spsel = '0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    settle();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_wr", 64'(out_wr), 64'd0);
    tick();

    // 1: SP banking with bank 2 and link alias.
    spsel_we = 1; spsel = 3'd2;
    cyc();
    spsel_we = 0;
    in_valid = 1;
    in_cls = {3'(RC_JXX), 3'(RC_R3)};
    in_fld = {6'd29, 6'd31};
    cyc();
    idle();
    settle();
    chk("t1_lane0_rc", 64'(out_rc[5:0]), 64'd45);
    chk("t1_lane1_rc", 64'(out_rc[11:6]), 64'd41);
    chk("t1_wr", 64'(out_wr), 64'b11);
    tick();
    settle();
    chk("t1_busy45", 64'(busy[45]), 64'd1);
    chk("t1_busy41", 64'(busy[41]), 64'd1);
    tick();

    // 2: WAW stall on r5 until its write-back retires.
    in_valid = 1;
    in_cls = {3'(RC_NONE), 3'(RC_R3)};
    in_fld = {6'd0, 6'd5};
    cyc();
    repeat (3) begin
      settle();
      chk("t2_stalled", 64'(in_ready), 64'd0);
      tick();
    end
    wb_v = 1; wb_reg = 6'd5;
    settle();
    chk("t2_accept_on_wb", 64'(in_ready), 64'd1);
    tick();
    idle();
    settle();
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    tick();
    cyc();

    // 3: duplicate target inside a group.
    in_valid = 1;
    in_cls = {3'(RC_R3), 3'(RC_R3)};
    in_fld = {6'd7, 6'd7};
    cyc();
    idle();
    settle();
    chk("t3_wr", 64'(out_wr), 64'b10);
    chk("t3_rc1", 64'(out_rc[11:6]), 64'd7);
    tick();
    cyc();

    // 4: back-pressure fills the buffer.
    out_ready = 0;
    in_valid = 1;
    in_cls = {3'(RC_R3), 3'(RC_R3)};
    for (int i = 0; i < 4; i++) begin
      in_fld = {6'(11 + 2 * i), 6'(10 + 2 * i)};
      settle();
      if (i >= 2) begin
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        chk("t4_hold_rc", 64'(out_rc), 64'({6'd11, 6'd10}));
      end
      tick();
    end

    // 5: flush the two buffered groups, then async reset mid-stream.
    idle();
    flush = 1;
    cyc();
    flush = 0;
    settle();
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_busy", busy,
        (64'd1 << 5) | (64'd1 << 7) | (64'd1 << 41) | (64'd1 << 45));
    tick();
    out_ready = 1;
    async_reset();
    cyc();

    // 6: write-back and handshake set of the same register in one cycle.
    in_valid = 1;
    in_cls = {3'(RC_NONE), 3'(RC_R3)};
    in_fld = {6'd0, 6'd9};
    cyc();
    idle();
    wb_v = 1; wb_reg = 6'd9;
    cyc();
    wb_v = 0;
    settle();
    chk("t6_set_wins", 64'(busy[9]), 64'd1);
    tick();

    // Random traffic against the model, with one asynchronous reset inside.
    for (int it = 0; it < 400; it++) begin
      if (it == 200) async_reset();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      spsel_we  = ($urandom_range(0, 9) == 0);
      spsel     = 3'($urandom_range(0, 7));
      for (int l = 0; l < 2; l++) begin
        in_cls[l*3 +: 3] = 3'($urandom_range(0, 5));
        case ($urandom_range(0, 3))
          0:       in_fld[l*6 +: 6] = 6'($urandom_range(0, 63));
          1:       in_fld[l*6 +: 6] = 6'(29 + $urandom_range(0, 2));
          default: in_fld[l*6 +: 6] = 6'($urandom_range(0, 15));
        endcase
      end
      wb_v   = ($urandom_range(0, 1) == 1);
      wb_reg = 6'($urandom_range(0, 63));
      if (m_busy != 64'd0)
        for (int k = 0; k < 64; k++) begin
          r = $urandom_range(0, 63);
          if (m_busy[r]) begin
            wb_reg = 6'(r);
            break;
          end
        end
      cyc();
    end

    idle();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
